// File: rtl/kulisch_acc_resolve.sv
// rtl/kulisch_acc_resolve.sv - Kulisch sum/carry accumulator with chunked resolve to FP32 (RNE).
// Optional build macro KULISCH_RESOLVE_INEXACT_EN adds the o_inexact output.
module kulisch_acc_resolve #(
  parameter int AWIDTH = 92,
  parameter int FRAC   = 48,
  parameter int NCHUNK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_last,
  input  logic [AWIDTH-1:0] i_sum_acc,
  input  logic [AWIDTH-1:0] i_carry_acc,
  output logic [AWIDTH-1:0] o_sum_acc,
  output logic [AWIDTH-1:0] o_carry_acc,
  output logic              o_valid,
  input  logic              i_ready,
`ifdef KULISCH_RESOLVE_INEXACT_EN
  output logic              o_inexact,
`endif
  output logic [31:0]       o_data
);

  localparam int CW = AWIDTH / NCHUNK;
  localparam int PW = $clog2(AWIDTH);
  localparam int NW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [2:0] {IDLE, ADD, NORM, RND, OUT} state_t;
  state_t state, state_next;

  logic [AWIDTH-1:0] snap_sum, snap_carry, resolved, mag;
  logic [NW-1:0]     chunk;
  logic              chunk_cin;
  logic [CW:0]       chunk_add;
  logic              sign, zero;
  logic [PW-1:0]     lead, lead_c;
  logic [AWIDTH-2:0] frac;  // bits below the leading one, left-aligned
  logic [22:0]       man, man_rnd;
  logic              guard, sticky, round_up, man_ovf;
  logic [7:0]        exp_c;
  logic              accept, last_chunk;

  assign o_ready    = !i_last || (state == IDLE);
  assign accept     = i_valid && o_ready;
  assign last_chunk = (chunk == NW'(NCHUNK - 1));
  assign o_valid    = (state == OUT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && i_last) state_next = ADD;
      ADD:     if (last_chunk) state_next = NORM;
      NORM:    state_next = RND;
      RND:     state_next = OUT;
      OUT:     if (i_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A last beat hands its value to the resolver and restarts the accumulator at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_sum_acc   <= '0;
      o_carry_acc <= '0;
      snap_sum    <= '0;
      snap_carry  <= '0;
    end else if (accept) begin
      if (i_last) begin
        snap_sum    <= i_sum_acc;
        snap_carry  <= i_carry_acc;
        o_sum_acc   <= '0;
        o_carry_acc <= '0;
      end else begin
        o_sum_acc   <= i_sum_acc;
        o_carry_acc <= i_carry_acc;
      end
    end
  end

  always_comb begin
    chunk_add = {1'b0, snap_sum[chunk*CW +: CW]} + {1'b0, snap_carry[chunk*CW +: CW]}
              + {{CW{1'b0}}, chunk_cin};
    mag    = resolved[AWIDTH-1] ? -resolved : resolved;
    lead_c = '0;
    for (int i = 0; i < AWIDTH; i++)
      if (mag[i]) lead_c = PW'(i);
  end

  always_comb begin
    man      = frac[AWIDTH-2 -: 23];
    guard    = frac[AWIDTH-25];
    sticky   = |frac[AWIDTH-26:0];
    round_up = guard && (sticky || man[0]);
    {man_ovf, man_rnd} = {1'b0, man} + 24'(round_up);
    exp_c    = 8'(lead) + 8'(127 - FRAC) + 8'(man_ovf);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chunk     <= '0;
      chunk_cin <= 1'b0;
      resolved  <= '0;
      sign      <= 1'b0;
      zero      <= 1'b0;
      lead      <= '0;
      frac      <= '0;
      o_data    <= '0;
    end else begin
      case (state)
        IDLE: begin
          chunk     <= '0;
          chunk_cin <= 1'b0;
        end
        ADD: begin
          resolved[chunk*CW +: CW] <= chunk_add[CW-1:0];
          chunk_cin                <= chunk_add[CW];
          chunk                    <= chunk + 1'b1;
        end
        NORM: begin
          sign <= resolved[AWIDTH-1];
          zero <= (mag == '0);
          lead <= lead_c;
          frac <= mag[AWIDTH-2:0] << (PW'(AWIDTH - 1) - lead_c);
        end
        RND:     o_data <= zero ? 32'h0 : {sign, exp_c, man_rnd};
        default: ;
      endcase
    end
  end

`ifdef KULISCH_RESOLVE_INEXACT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        o_inexact <= 1'b0;
    else if (state == RND)          o_inexact <= guard || sticky;
    else if (state == OUT && i_ready) o_inexact <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_kulisch_acc_resolve.sv
// tb/tb_kulisch_acc_resolve.sv - Randomized self-checking bench for kulisch_acc_resolve.
module tb_kulisch_acc_resolve;
  localparam int AW   = 92;
  localparam int FRAC = 48;
  localparam int LAT  = 4 + 3;

  logic clk = 1'b0;
  logic rst, i_valid, i_last, i_ready, o_ready, o_valid;
  logic [AW-1:0] i_sum_acc, i_carry_acc, o_sum_acc, o_carry_acc;
  logic [31:0] o_data;
`ifdef KULISCH_RESOLVE_INEXACT_EN
  logic o_inexact;
`endif
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  kulisch_acc_resolve #(.AWIDTH(AW), .FRAC(FRAC), .NCHUNK(4)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_last(i_last),
    .i_sum_acc(i_sum_acc), .i_carry_acc(i_carry_acc),
    .o_sum_acc(o_sum_acc), .o_carry_acc(o_carry_acc),
    .o_valid(o_valid), .i_ready(i_ready),
`ifdef KULISCH_RESOLVE_INEXACT_EN
    .o_inexact(o_inexact),
`endif
    .o_data(o_data)
  );

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] rand_wide();
    return AW'({$urandom, $urandom, $urandom});
  endfunction

  // {inexact, fp32} of the real number (s+c mod 2^AW, signed) * 2^-FRAC, rounded to nearest even
  function automatic logic [32:0] ref_fp32(input logic [AW-1:0] s, input logic [AW-1:0] c);
    logic [AW-1:0] tot, mag, rem, half;
    logic [24:0] m;
    logic sgn;
    int p, e;
    tot = s + c;
    sgn = tot[AW-1];
    mag = sgn ? (AW'(0) - tot) : tot;
    if (mag == 0) return 33'h0;
    p = AW - 1;
    while (mag[p] == 1'b0) p--;
    rem = '0;
    if (p > 23) begin
      m    = 25'(mag >> (p - 23));
      rem  = mag & ((AW'(1) << (p - 23)) - AW'(1));
      half = AW'(1) << (p - 24);
      if (rem > half || (rem == half && m[0])) m = m + 25'd1;
      if (m == 25'h1000000) begin
        m = m >> 1;
        p++;
      end
    end else begin
      m = 25'(mag << (23 - p));
    end
    e = p - FRAC + 127;
    return {rem != 0, sgn, 8'(e), m[22:0]};
  endfunction

  // Called at a negedge with the resolver idle; returns at a negedge after the handshake.
  task automatic convert(input string tag, input logic [AW-1:0] s, input logic [AW-1:0] c,
                         input logic [32:0] exp_r, input bit feed);
    logic [AW-1:0] es, ec;
    int k, n;
    i_valid = 1'b1; i_last = 1'b1; i_sum_acc = s; i_carry_acc = c; i_ready = 1'b1;
    n = 0;
    while (!o_ready && n < 20) begin @(negedge clk); n++; end
    check({tag, "_rdy"}, o_ready, 1);
    @(negedge clk);
    es = '0; ec = '0; k = 1;
    while (!o_valid && k < 20) begin
      check({tag, "_acc"}, {o_sum_acc, o_carry_acc}, {es, ec});
      if (feed && k <= 3) begin
        i_valid = 1'b1; i_last = 1'b0;
        es = rand_wide(); ec = rand_wide();
        i_sum_acc = es; i_carry_acc = ec;
      end else begin
        i_valid = 1'b0; i_last = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    i_valid = 1'b0; i_last = 1'b0;
    check({tag, "_lat"}, k, LAT);
    check({tag, "_valid"}, o_valid, 1);
    check({tag, "_data"}, o_data, exp_r[31:0]);
`ifdef KULISCH_RESOLVE_INEXACT_EN
    check({tag, "_inexact"}, o_inexact, exp_r[32]);
`endif
    @(negedge clk);
    check({tag, "_drop"}, o_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] s, c, v;
    logic seen;
    int n;
    rst = 1'b1; i_valid = 1'b0; i_last = 1'b1; i_ready = 1'b1;
    i_sum_acc = '0; i_carry_acc = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", o_valid, 0);
    check("rst_data", o_data, 0);
    check("rst_acc", {o_sum_acc, o_carry_acc}, 0);
    check("rst_ready", o_ready, 1);
    rst = 1'b0; i_last = 1'b0;
    @(negedge clk);

    convert("one", AW'(1) << 48, '0, {1'b0, 32'h3F800000}, 1'b0);
    check("one_acc_after", {o_sum_acc, o_carry_acc}, 0);
    convert("neg_two", AW'(1) << 48, AW'(0) - (AW'(3) << 48), {1'b0, 32'hC0000000}, 1'b0);
    convert("zero", '0, '0, {1'b0, 32'h00000000}, 1'b0);
    convert("tie_even", ((AW'(1) << 24) + AW'(1)) << 48, '0, {1'b1, 32'h4B800000}, 1'b0);
    convert("tie_up", ((AW'(1) << 24) + AW'(3)) << 48, '0, {1'b1, 32'h4B800002}, 1'b0);
    convert("tiny", AW'(1), '0, {1'b0, 32'h27800000}, 1'b0);

    for (int i = 0; i < 3; i++) begin
      v = (i == 0) ? AW'(5) : (i == 1) ? AW'(9) : AW'(12);
      i_valid = 1'b1; i_last = 1'b0; i_sum_acc = v; i_carry_acc = AW'(i);
      @(negedge clk);
      check("accum", {o_sum_acc, o_carry_acc}, {v, AW'(i)});
    end
    i_valid = 1'b0;
    convert("feed", AW'(12), AW'(7) << 48, ref_fp32(AW'(12), AW'(7) << 48), 1'b1);

    // Consumer stalls while a second last beat waits for the drain.
    i_ready = 1'b0; i_valid = 1'b1; i_last = 1'b1;
    i_sum_acc = AW'(1) << 48; i_carry_acc = '0;
    @(negedge clk);
    i_sum_acc = AW'(3) << 48;
    n = 1;
    while (!o_valid && n < 20) begin @(negedge clk); n++; end
    check("hold_lat", n, LAT);
    for (int i = 0; i < 10; i++) begin
      check("hold_valid", o_valid, 1);
      check("hold_data", o_data, 32'h3F800000);
      check("hold_ready", o_ready, 0);
      @(negedge clk);
    end
    i_ready = 1'b1;
    check("drain_ready", o_ready, 0);
    @(negedge clk);
    check("drain_valid", o_valid, 0);
    check("drain_idle_ready", o_ready, 1);
    convert("second", AW'(3) << 48, '0, {1'b0, 32'h40400000}, 1'b0);

    // Reset in the middle of the chunked add.
    i_valid = 1'b1; i_last = 1'b1; i_sum_acc = rand_wide(); i_carry_acc = rand_wide();
    @(negedge clk);
    i_valid = 1'b0; i_last = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_valid", o_valid, 0);
    check("abort_data", o_data, 0);
    check("abort_acc", {o_sum_acc, o_carry_acc}, 0);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      seen = seen | o_valid;
    end
    check("abort_novalid", seen, 0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0: begin s = rand_wide(); c = rand_wide(); end
        1: begin
          s = AW'($urandom) << $urandom_range(0, 58);
          c = AW'(0) - (AW'($urandom) << $urandom_range(0, 58));
        end
        default: begin
          v = AW'({1'b1, 23'($urandom), 1'b1}) << $urandom_range(0, 66);
          if ($urandom_range(0, 1) == 1) v = AW'(0) - v;
          c = rand_wide();
          s = v - c;
        end
      endcase
      convert("rand", s, c, ref_fp32(s, c), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/kulisch_acc_resolve.md
Name: kulisch_acc_resolve

Overview:
- Downstream of the FP16 Kulisch carry-save accumulation stage.
- Holds the 92-bit sum/carry accumulator registers and feeds them back to the CSA tree. On each valid beat it captures the tree's new sum/carry.
- On the last beat of a dot product it snapshots the accumulator, resolves it with a multi-cycle chunked carry-propagate add, then normalizes and rounds to FP32 (round-to-nearest-even). The result leaves on a valid/ready interface.

Parameters:
- AWIDTH, 92: accumulator width; two's-complement fixed point.
- FRAC, 48: fraction bits; value = signed(sum+carry mod 2^AWIDTH) * 2^-FRAC.
- NCHUNK, 4: carry-propagate chunks; AWIDTH % NCHUNK == 0 (chunk = 23 bits).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- i_valid  in  1  tree result valid
- o_ready  out  1  beat accepted when i_valid && o_ready
- i_last  in  1  final beat of a dot product
- i_sum_acc  in  AWIDTH  tree sum output
- i_carry_acc  in  AWIDTH  tree carry output
- o_sum_acc  out  AWIDTH  accumulator sum register, fed back to the tree
- o_carry_acc  out  AWIDTH  accumulator carry register, fed back to the tree
- o_valid  out  1  FP32 result valid
- i_ready  in  1  consumer ready
- o_data  out  32  FP32 result {sign, exp[7:0], man[22:0]}

Behaviour:
- Reset: acc registers = 0, state = IDLE, o_valid = 0, o_data = 0. Reset mid-resolve aborts the conversion; no partial result is emitted.
- Accumulate: on an accepted beat with i_last=0, acc registers load i_sum_acc/i_carry_acc on the next edge.
- Last beat: on an accepted beat with i_last=1:
  - the snapshot registers take i_sum_acc/i_carry_acc;
  - the acc registers clear to 0;
  - the FSM moves IDLE->ADD.
- Ready rule: o_ready = !i_last || (state==IDLE). Non-last beats are always accepted, including during a resolve. o_ready must not depend on i_valid.
- FSM states: IDLE -> ADD -> NORM -> RND -> OUT -> IDLE.
- ADD: NCHUNK cycles. Cycle j adds chunk j (LSB first) of the sum and carry snapshots plus a registered carry-in (0 for j=0). The result is written into the resolved register. The carry-out past the top chunk is discarded (mod 2^AWIDTH).
- NORM:
  - sign = MSB of resolved value; magnitude = two's-complement negation if negative.
  - Leading-one position p is found over AWIDTH bits.
  - Magnitude is left-aligned to bit AWIDTH-1.
  - Zero magnitude -> flag zero.
- RND:
  - mantissa = 23 bits below the leading one; guard = next bit; sticky = OR of the rest.
  - Round up if guard && (sticky || lsb).
  - Mantissa overflow from rounding increments the exponent.
  - exp = p - FRAC + 127, always in range 79..170, so there are no denormals or overflow.
  - Zero produces 0x00000000 (+0).
- OUT: o_valid=1 and o_data stable until i_ready. Handshake completes -> IDLE with o_valid=0 on the next edge.
- Latency: last beat accepted in cycle T -> o_valid first high in cycle T+NCHUNK+3 (T+7 at default), with i_ready high from that cycle.
- Simultaneous events: in the cycle OUT completes, o_ready stays 0 for a last beat; that beat is accepted in the next cycle (IDLE).

Optional Feature:
- Macro KULISCH_RESOLVE_INEXACT_EN.
- Defined: adds output port o_inexact (1 bit) = guard|sticky of the current result. It is valid and held alongside o_valid, and reset to 0.
- Undefined: the port and its logic are absent. o_data is identical in both builds.

Test Plan:
- Single beat, i_last=1, sum=1<<48, carry=0 -> o_data=0x3F800000, exactly 7 cycles after accept; o_sum_acc/o_carry_acc read 0 afterwards.
- sum=1<<48, carry=-(3<<48) mod 2^92 -> o_data=0xC0000000. sum=carry=0 -> o_data=0x00000000.
- sum=(2^24+1)<<48 -> 0x4B800000 (tie, round to even), o_inexact=1. sum=(2^24+3)<<48 -> 0x4B800002 (tie, round up). sum=1 -> 0x27800000.
- Three non-last beats with values 5, 9, 12 -> o_sum_acc tracks each captured value on the following edge. A last beat then converts; accumulation continues during ADD and the result is unaffected.
- Hold i_ready=0 for 10 cycles in OUT -> o_data stable. A second last beat presented meanwhile sees o_ready=0 and is accepted only after the drain.
- Assert rst during ADD -> o_valid never rises for that conversion; all outputs are 0; the next conversion is correct.
